cam_match_scanner: RTL and testbench

CAM_MATCH_SCANNER -- requirements
Module: cam_match_scanner

---
 rtl/cam_match_scanner.sv | 110 +++++++++++
 tb/tb_cam_match_scanner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_match_scanner.sv
// CAM match-line scanner: captures a raw match vector and emits the hit entry
// indices one per accepted beat, lowest index first, or a single miss beat.
module cam_match_scanner #(
   parameter int MUX_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [MUX_WIDTH-1:0]         match_line,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(MUX_WIDTH)-1:0] out_index,
   output logic                         out_miss,
   output logic                         out_last,
   output logic [$clog2(MUX_WIDTH):0]   out_hits
);

   localparam int MUX_INDEX = $clog2(MUX_WIDTH);

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   state_t                 state;
   logic [MUX_WIDTH-1:0]   pending;
   logic [MUX_WIDTH-1:0]   clearMask;
   logic [MUX_WIDTH-1:0]   scanNext;

   // Lowest-index-wins priority encoder; an empty vector encodes as 0.
   function automatic logic [MUX_INDEX-1:0] lowestIndex(input logic [MUX_WIDTH-1:0] vec);
      logic [MUX_INDEX-1:0] idx;
      idx = '0;
      for (int i = MUX_WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = MUX_INDEX'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic [MUX_INDEX:0] popCount(input logic [MUX_WIDTH-1:0] vec);
      logic [MUX_INDEX:0] cnt;
      cnt = '0;
      for (int i = 0; i < MUX_WIDTH; i++) begin
         if (vec[i]) begin
            cnt = cnt + (MUX_INDEX+1)'(1);
         end
      end
      return cnt;
   endfunction

   // True for zero or one set bit: both cases produce the final beat of a vector.
   function automatic logic atMostOne(input logic [MUX_WIDTH-1:0] vec);
      return (vec & (vec - MUX_WIDTH'(1))) == '0;
   endfunction

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == SCAN);

   assign clearMask = ~({{(MUX_WIDTH-1){1'b0}}, 1'b1} << out_index);
   assign scanNext  = pending & clearMask;

   // Beat outputs are registered from the vector that will be pending after the edge,
   // so they stay frozen for free while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pending   <= '0;
         out_index <= '0;
         out_miss  <= 1'b0;
         out_last  <= 1'b0;
         out_hits  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state     <= SCAN;
                  pending   <= match_line;
                  out_hits  <= popCount(match_line);
                  out_index <= lowestIndex(match_line);
                  out_miss  <= (match_line == '0);
                  out_last  <= atMostOne(match_line);
               end
            end
            SCAN: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= IDLE;
                     pending   <= '0;
                     out_index <= '0;
                     out_miss  <= 1'b0;
                     out_last  <= 1'b0;
                  end else begin
                     pending   <= scanNext;
                     out_index <= lowestIndex(scanNext);
                     out_miss  <= 1'b0;
                     out_last  <= atMostOne(scanNext);
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_match_scanner.sv
// Scoreboard bench for cam_match_scanner: directed cases plus randomized vectors
// with random backpressure, checked against a bit-loop reference model.
module tb_cam_match_scanner;

   localparam int W  = 16;
   localparam int IW = 4;

   typedef struct {
      logic [IW-1:0] idx;
      logic          miss;
      logic          last;
      logic [IW:0]   hits;
   } beat_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  match_line;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_index;
   logic          out_miss;
   logic          out_last;
   logic [IW:0]   out_hits;

   int    checks = 0;
   int    errors = 0;
   int    readyMode = 0;
   beat_t expQ[$];

   cam_match_scanner #(.MUX_WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .match_line (match_line),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_index  (out_index),
      .out_miss   (out_miss),
      .out_last   (out_last),
      .out_hits   (out_hits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: walk the bits upward, one beat per hit, one miss beat if none.
   task automatic pushExpected(input logic [W-1:0] vec);
      beat_t b;
      int    total;
      int    seen;
      total = $countones(vec);
      seen  = 0;
      if (total == 0) begin
         b.idx = '0; b.miss = 1'b1; b.last = 1'b1; b.hits = '0;
         expQ.push_back(b);
      end else begin
         for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
               seen++;
               b.idx  = IW'(i);
               b.miss = 1'b0;
               b.last = (seen == total);
               b.hits = (IW+1)'(total);
               expQ.push_back(b);
            end
         end
      end
   endtask

   // Waits for in_ready (bounded), presents one vector for exactly one edge.
   task automatic applyStimulus(input logic [W-1:0] vec);
      int n;
      n = 0;
      while (!in_ready && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checkOutput("in_ready_timeout", 0, 1);
      end else begin
         in_valid   = 1'b1;
         match_line = vec;
         pushExpected(vec);
         @(posedge clk); #1;
         in_valid   = 1'b0;
         match_line = W'($urandom);
      end
   endtask

   // Pulses in_valid with junk data while the scanner is busy; it must be ignored.
   task automatic junkPulses(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         if (out_valid) begin
            in_valid   = 1'b1;
            match_line = W'($urandom);
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((expQ.size() != 0 || out_valid) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("drain_timeout", (expQ.size() == 0 && !out_valid) ? 1 : 0, 1);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         if (readyMode == 0)      out_ready = 1'b1;
         else if (readyMode == 1) out_ready = 1'($urandom_range(0, 1));
         else                     out_ready = 1'b0;
      end
   end

   // Monitor: pops on every accepted beat and checks hold-stability during stalls.
   initial begin
      beat_t exp;
      beat_t held;
      logic  stalled;
      stalled = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
         end else begin
            if (stalled && out_valid) begin
               checkOutput("hold_index", int'(out_index), int'(held.idx));
               checkOutput("hold_flags", int'({out_miss, out_last}), int'({held.miss, held.last}));
               checkOutput("hold_hits", int'(out_hits), int'(held.hits));
            end
            if (out_valid && out_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_beat", int'(out_index), -1);
               end else begin
                  exp = expQ.pop_front();
                  checkOutput("beat_index", int'(out_index), int'(exp.idx));
                  checkOutput("beat_miss", int'(out_miss), int'(exp.miss));
                  checkOutput("beat_last", int'(out_last), int'(exp.last));
                  checkOutput("beat_hits", int'(out_hits), int'(exp.hits));
               end
            end
            stalled   = out_valid && !out_ready;
            held.idx  = out_index;
            held.miss = out_miss;
            held.last = out_last;
            held.hits = out_hits;
         end
      end
   end

   initial begin
      logic [W-1:0] v;
      int           sawValid;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      match_line = '0;
      out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", int'(in_ready), 1);
      checkOutput("reset_out_valid", int'(out_valid), 0);
      checkOutput("reset_outputs", int'({out_index, out_miss, out_last, out_hits}), 0);
      rst_n = 1'b1;

      // Single hit: result one cycle after capture, ready again the cycle after.
      applyStimulus(16'h0100);
      checkOutput("latency_out_valid", int'(out_valid), 1);
      checkOutput("latency_in_ready_low", int'(in_ready), 0);
      @(posedge clk); #1;
      checkOutput("single_in_ready_back", int'(in_ready), 1);

      applyStimulus(16'h8421);
      drain();
      applyStimulus(16'h0000);
      drain();

      // Backpressure with junk input pulses during SCAN.
      readyMode = 2;
      @(posedge clk); #1;
      applyStimulus(16'h0006);
      for (int c = 0; c < 3; c++) begin
         checkOutput("bp_valid", int'(out_valid), 1);
         checkOutput("bp_index", int'(out_index), 1);
         junkPulses(1);
      end
      readyMode = 0;
      junkPulses(4);
      drain();

      applyStimulus(16'hFFFF);
      drain();

      // Reset mid-scan after the second beat has been accepted.
      applyStimulus(16'hF000);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      expQ.delete();
      #1;
      checkOutput("midreset_out_valid", int'(out_valid), 0);
      checkOutput("midreset_in_ready", int'(in_ready), 1);
      checkOutput("midreset_outputs", int'({out_index, out_miss, out_last, out_hits}), 0);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      sawValid = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid) sawValid++;
      end
      checkOutput("no_residual_beats", sawValid, 0);

      applyStimulus(16'h0011);
      drain();

      // Randomized vectors with random backpressure.
      readyMode = 1;
      for (int t = 0; t < 80; t++) begin
         case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = W'(1) << $urandom_range(0, W - 1);
            3:       v = W'($urandom) & W'($urandom) & W'($urandom);
            default: v = W'($urandom);
         endcase
         applyStimulus(v);
         if ($urandom_range(0, 3) == 0) junkPulses($urandom_range(1, 4));
      end
      readyMode = 0;
      drain();
      checkOutput("scoreboard_empty", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
